// File: rtl/multibuf_read_router.sv
// Routes FFT and DMA read ports onto a rotating set of RAM banks.
// Define MULTIBUF_READ_OUTREG_EN to register rdr_*/rdv_* (latency RD_LAT+1).
module multibuf_read_router #(
    parameter int FFT_N     = 10,
    parameter int FFT_DW    = 16,
    parameter int NUM_BANKS = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ract_fft,
    input  logic [FFT_N-2:0]                     ra_fft,
    output logic [FFT_DW*2-1:0]                  rdr_fft,
    output logic                                 rdv_fft,
    input  logic                                 ract_dma,
    input  logic [FFT_N-2:0]                     ra_dma,
    output logic [FFT_DW*2-1:0]                  rdr_dma,
    output logic                                 rdv_dma,
    output logic [NUM_BANKS-1:0]                 ract_ram,
    output logic [NUM_BANKS*(FFT_N-1)-1:0]       ra_ram,
    input  logic [NUM_BANKS*FFT_DW*2-1:0]        rdr_ram,
    input  logic                                 adv_req,
    output logic                                 adv_ack,
    output logic                                 rd_stall,
    output logic [$clog2(NUM_BANKS)-1:0]         phase,
    output logic                                 drop_err
);

    localparam int AW = FFT_N - 1;
    localparam int DW = FFT_DW * 2;
    localparam int PW = $clog2(NUM_BANKS);
    localparam logic [PW:0]   NB_W    = (PW+1)'(NUM_BANKS);
    localparam logic [PW-1:0] LAST_PH = PW'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ADV   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             phase_q, phase_d;
    logic                      drop_err_q, drop_err_d;
    logic [RD_LAT-1:0]         fv_q, fv_d;
    logic [RD_LAT-1:0]         dv_q, dv_d;
    logic [RD_LAT-1:0][PW-1:0] fb_q, fb_d;
    logic [RD_LAT-1:0][PW-1:0] db_q, db_d;

    logic [NUM_BANKS-1:0][PW:0] role;
    logic [PW-1:0]              fft_bank;
    logic [PW-1:0]              dma_bank;
    logic                       stall;
    logic                       fft_go;
    logic                       dma_go;
    logic                       pipe_busy;
    logic                       out_busy;
    logic                       fft_vld;
    logic                       dma_vld;
    logic [DW-1:0]              fft_rd;
    logic [DW-1:0]              dma_rd;

    // b + phase never exceeds 2*NUM_BANKS-2, so one subtraction is a full mod
    always_comb begin
        role     = '0;
        fft_bank = '0;
        dma_bank = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            role[b] = (PW+1)'(b) + {1'b0, phase_q};
            if (role[b] >= NB_W) begin
                role[b] = role[b] - NB_W;
            end
            if (role[b] == (PW+1)'(1)) begin
                fft_bank = PW'(b);
            end
            if (role[b] == (PW+1)'(2)) begin
                dma_bank = PW'(b);
            end
        end
    end

    assign stall  = (state_q == ADV);
    assign fft_go = ract_fft & ~stall;
    assign dma_go = ract_dma & ~stall;

    always_comb begin
        ract_ram = '0;
        ra_ram   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (role[b] == (PW+1)'(1)) begin
                ract_ram[b]         = fft_go;
                ra_ram[b*AW +: AW]  = ra_fft;
            end else if (role[b] == (PW+1)'(2)) begin
                ract_ram[b]         = dma_go;
                ra_ram[b*AW +: AW]  = ra_dma;
            end
        end
    end

    // Bank index travels with the strobe so a read survives a later rotation
    always_comb begin
        fv_d    = fv_q;
        dv_d    = dv_q;
        fb_d    = fb_q;
        db_d    = db_q;
        fv_d[0] = fft_go;
        dv_d[0] = dma_go;
        fb_d[0] = fft_bank;
        db_d[0] = dma_bank;
        for (int i = 1; i < RD_LAT; i++) begin
            fv_d[i] = fv_q[i-1];
            dv_d[i] = dv_q[i-1];
            fb_d[i] = fb_q[i-1];
            db_d[i] = db_q[i-1];
        end
    end

    always_comb begin
        fft_vld = fv_q[RD_LAT-1];
        dma_vld = dv_q[RD_LAT-1];
        fft_rd  = '0;
        dma_rd  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (fft_vld && fb_q[RD_LAT-1] == PW'(b)) begin
                fft_rd = rdr_ram[b*DW +: DW];
            end
            if (dma_vld && db_q[RD_LAT-1] == PW'(b)) begin
                dma_rd = rdr_ram[b*DW +: DW];
            end
        end
    end

    assign pipe_busy = (|fv_q) | (|dv_q);

`ifdef MULTIBUF_READ_OUTREG_EN
    logic          fo_v_q, fo_v_d;
    logic          do_v_q, do_v_d;
    logic [DW-1:0] fo_r_q, fo_r_d;
    logic [DW-1:0] do_r_q, do_r_d;

    always_comb begin
        fo_v_d = fft_vld;
        do_v_d = dma_vld;
        fo_r_d = fft_rd;
        do_r_d = dma_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fo_v_q <= 1'b0;
            do_v_q <= 1'b0;
            fo_r_q <= '0;
            do_r_q <= '0;
        end else begin
            fo_v_q <= fo_v_d;
            do_v_q <= do_v_d;
            fo_r_q <= fo_r_d;
            do_r_q <= do_r_d;
        end
    end

    assign rdv_fft  = fo_v_q;
    assign rdr_fft  = fo_r_q;
    assign rdv_dma  = do_v_q;
    assign rdr_dma  = do_r_q;
    assign out_busy = fo_v_q | do_v_q;
`else
    assign rdv_fft  = fft_vld;
    assign rdr_fft  = fft_rd;
    assign rdv_dma  = dma_vld;
    assign rdr_dma  = dma_rd;
    assign out_busy = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        drop_err_d = drop_err_q;
        adv_ack    = 1'b0;
        rd_stall   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (adv_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!ract_fft && !ract_dma && !pipe_busy && !out_busy) begin
                    state_d = ADV;
                end
            end
            ADV: begin
                rd_stall = 1'b1;
                adv_ack  = 1'b1;
                state_d  = RUN;
                phase_d  = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
                if (ract_fft || ract_dma) begin
                    drop_err_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            phase_q    <= '0;
            drop_err_q <= 1'b0;
            fv_q       <= '0;
            dv_q       <= '0;
            fb_q       <= '0;
            db_q       <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            drop_err_q <= drop_err_d;
            fv_q       <= fv_d;
            dv_q       <= dv_d;
            fb_q       <= fb_d;
            db_q       <= db_d;
        end
    end

    assign phase    = phase_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_multibuf_read_router.sv
// Bench for multibuf_read_router: bank RAM model, due-slot scoreboard
// and directed scenarios plus randomized reads/rotations.
module tb_multibuf_read_router;

    localparam int FFT_N  = 6;
    localparam int FFT_DW = 8;
    localparam int NB     = 5;
    localparam int RDL    = 3;
    localparam int AW     = FFT_N - 1;
    localparam int DW     = FFT_DW * 2;
    localparam int PW     = $clog2(NB);
`ifdef MULTIBUF_READ_OUTREG_EN
    localparam int LAT    = RDL + 1;
`else
    localparam int LAT    = RDL;
`endif
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_ADV   = 2;

    logic              clk;
    logic              rst_n;
    logic              ract_fft;
    logic [AW-1:0]     ra_fft;
    logic [DW-1:0]     rdr_fft;
    logic              rdv_fft;
    logic              ract_dma;
    logic [AW-1:0]     ra_dma;
    logic [DW-1:0]     rdr_dma;
    logic              rdv_dma;
    logic [NB-1:0]     ract_ram;
    logic [NB*AW-1:0]  ra_ram;
    logic [NB*DW-1:0]  rdr_ram;
    logic              adv_req;
    logic              adv_ack;
    logic              rd_stall;
    logic [PW-1:0]     phase;
    logic              drop_err;

    int checks = 0;
    int fails  = 0;

    multibuf_read_router #(
        .FFT_N(FFT_N), .FFT_DW(FFT_DW), .NUM_BANKS(NB), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ract_fft(ract_fft), .ra_fft(ra_fft), .rdr_fft(rdr_fft), .rdv_fft(rdv_fft),
        .ract_dma(ract_dma), .ra_dma(ra_dma), .rdr_dma(rdr_dma), .rdv_dma(rdv_dma),
        .ract_ram(ract_ram), .ra_ram(ra_ram), .rdr_ram(rdr_ram),
        .adv_req(adv_req), .adv_ack(adv_ack), .rd_stall(rd_stall),
        .phase(phase), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mdata(int b, logic [AW-1:0] a);
        logic [7:0] lo;
        lo = 8'(int'(a) * 7 + b * 13 + 90);
        return {3'(b), a, lo};
    endfunction

    function automatic int bank_of(int r, int ph);
        for (int b = 0; b < NB; b++)
            if ((b + ph) % NB == r) return b;
        return 0;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bank RAMs: data appears RDL cycles after a strobe; junk otherwise
    logic [DW-1:0] rp [NB][RDL];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            for (int s = RDL - 1; s > 0; s--) rp[b][s] <= rp[b][s-1];
            rp[b][0] <= ract_ram[b] ? mdata(b, ra_ram[b*AW +: AW]) : DW'($urandom);
        end
    end
    always_comb begin
        rdr_ram = '0;
        for (int b = 0; b < NB; b++) rdr_ram[b*DW +: DW] = rp[b][RDL-1];
    end

    // Reference model: mode, phase, sticky drop and a due-cycle scoreboard
    int            m_mode, m_phase, pcnt, m_busy, m_due;
    logic          m_drop;
    logic          e_fv [64];
    logic          e_dv [64];
    logic [DW-1:0] e_fd [64];
    logic [DW-1:0] e_dd [64];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = M_RUN; m_phase = 0; m_drop = 1'b0; pcnt = 0;
            for (int i = 0; i < 64; i++) begin
                e_fv[i] = 1'b0; e_dv[i] = 1'b0; e_fd[i] = '0; e_dd[i] = '0;
            end
        end else begin
            m_busy = 0;
            for (int k = 0; k < LAT; k++)
                if (e_fv[(pcnt + k) % 64] || e_dv[(pcnt + k) % 64]) m_busy = 1;
            m_due = (pcnt + LAT) % 64;
            if (m_mode != M_ADV && ract_fft) begin
                e_fv[m_due] = 1'b1;
                e_fd[m_due] = mdata(bank_of(1, m_phase), ra_fft);
            end
            if (m_mode != M_ADV && ract_dma) begin
                e_dv[m_due] = 1'b1;
                e_dd[m_due] = mdata(bank_of(2, m_phase), ra_dma);
            end
            e_fv[pcnt % 64] = 1'b0;
            e_dv[pcnt % 64] = 1'b0;
            case (m_mode)
                M_RUN:   if (adv_req) m_mode = M_DRAIN;
                M_DRAIN: if (!ract_fft && !ract_dma && m_busy == 0) m_mode = M_ADV;
                default: begin
                    if (ract_fft || ract_dma) m_drop = 1'b1;
                    m_phase = (m_phase + 1) % NB;
                    m_mode  = M_RUN;
                end
            endcase
            pcnt++;
        end
    end

    logic [NB-1:0]    e_ract;
    logic [NB*AW-1:0] e_ra;
    int               c_fb, c_db, c_s;

    initial forever begin
        @(negedge clk);
        c_fb   = bank_of(1, m_phase);
        c_db   = bank_of(2, m_phase);
        c_s    = pcnt % 64;
        e_ract = '0;
        e_ra   = '0;
        e_ract[c_fb] = ract_fft && m_mode != M_ADV;
        e_ract[c_db] = ract_dma && m_mode != M_ADV;
        e_ra[c_fb*AW +: AW] = ra_fft;
        e_ra[c_db*AW +: AW] = ra_dma;
        chk("cmp_rdv_fft", rdv_fft, e_fv[c_s]);
        chk("cmp_rdr_fft", rdr_fft, e_fv[c_s] ? e_fd[c_s] : '0);
        chk("cmp_rdv_dma", rdv_dma, e_dv[c_s]);
        chk("cmp_rdr_dma", rdr_dma, e_dv[c_s] ? e_dd[c_s] : '0);
        chk("cmp_phase", phase, m_phase);
        chk("cmp_rd_stall", rd_stall, m_mode == M_ADV);
        chk("cmp_adv_ack", adv_ack, m_mode == M_ADV);
        chk("cmp_drop_err", drop_err, m_drop);
        chk("cmp_ract_ram", ract_ram, e_ract);
        chk("cmp_ra_ram", ra_ram, e_ra);
    end

    task automatic rotate();
        int got;
        got = 0;
        adv_req = 1'b1;
        for (int i = 0; i < 40 && got == 0; i++) begin
            step();
            #2;
            if (adv_ack) begin
                got = 1;
                adv_req = 1'b0;
            end
        end
        chk("rotate_ack", got, 1);
        adv_req = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int rdv_t, ack_t, cnt;

    initial begin
        rst_n = 1'b0; ract_fft = 1'b0; ra_fft = '0;
        ract_dma = 1'b0; ra_dma = '0; adv_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdv_fft", rdv_fft, 0);
        chk("rst_rdr_fft", rdr_fft, 0);
        chk("rst_phase", phase, 0);
        chk("rst_stall", rd_stall, 0);
        chk("rst_ack", adv_ack, 0);
        chk("rst_drop", drop_err, 0);
        rst_n = 1'b1;
        step();

        // phase 0: FFT on bank 1, DMA on bank 2
        ract_fft = 1'b1; ra_fft = 5'd5;
        #2;
        chk("t1_ract_ram", ract_ram, 5'b00010);
        chk("t1_ra_bank1", ra_ram[9:5], 5);
        step();
        ract_fft = 1'b0; ra_fft = '0;
        for (int i = 0; i < LAT - 1; i++) begin
            #2;
            chk("t1_rdv_early", rdv_fft, 0);
            step();
        end
        #2;
        chk("t1_rdv", rdv_fft, 1);
        chk("t1_rdr", rdr_fft, 16'h258A);
        step();

        rotate();
        chk("t2_phase1", phase, 1);
        ract_fft = 1'b1; ract_dma = 1'b1; ra_fft = 5'd3; ra_dma = 5'd9;
        #2;
        chk("t2_ract_ram", ract_ram, 5'b00011);
        chk("t2_ra_bank0", ra_ram[4:0], 3);
        chk("t2_ra_bank1", ra_ram[9:5], 9);
        step();
        ract_fft = 1'b0; ract_dma = 1'b0;
        repeat (3) rotate();
        chk("t2_phase4", phase, 4);
        ract_fft = 1'b1; ract_dma = 1'b1;
        #2;
        chk("t2_ract_ph4", ract_ram, 5'b01100);
        step();
        ract_fft = 1'b0; ract_dma = 1'b0;
        rotate();
        chk("t2_wrap", phase, 0);

        // DMA read in flight holds off the rotation
        repeat (2) step();
        ract_dma = 1'b1; ra_dma = 5'd7;
        step();
        ract_dma = 1'b0; adv_req = 1'b1;
        rdv_t = -1; ack_t = -1;
        for (int i = 0; i < 20 && ack_t < 0; i++) begin
            #2;
            if (rdv_dma && rdv_t < 0) begin
                rdv_t = i;
                chk("t3_rdr_dma", rdr_dma, 16'h47A5);
            end
            if (adv_ack) begin
                ack_t = i;
                adv_req = 1'b0;
            end
            step();
        end
        chk("t3_rdv_time", rdv_t, LAT - 1);
        chk("t3_ack_time", ack_t, LAT + 1);

        // read during ADV is dropped and flags drop_err
        repeat (2) step();
        adv_req = 1'b1;
        step();
        step();
        adv_req = 1'b0;
        #1;
        chk("t4_stall", rd_stall, 1);
        ract_fft = 1'b1; ra_fft = 5'd4;
        #1;
        chk("t4_ract_ram", ract_ram, 0);
        step();
        ract_fft = 1'b0;
        cnt = 0;
        repeat (LAT + 2) begin
            #2;
            if (rdv_fft) cnt++;
            step();
        end
        chk("t4_no_rdv", cnt, 0);
        chk("t4_drop", drop_err, 1);

        // randomized traffic, mostly honouring rd_stall
        for (int i = 0; i < 1500; i++) begin
            step();
            ract_fft = ($urandom % 3 == 0) && (!rd_stall || $urandom % 4 == 0);
            ract_dma = ($urandom % 3 == 0) && (!rd_stall || $urandom % 4 == 0);
            ra_fft   = AW'($urandom);
            ra_dma   = AW'($urandom);
            if ($urandom % 10 == 0) adv_req = ~adv_req;
        end
        ract_fft = 1'b0; ract_dma = 1'b0; adv_req = 1'b0;
        repeat (10) step();

        // reset during DRAIN with a read outstanding
        ract_fft = 1'b1; ra_fft = 5'd2;
        step();
        ract_fft = 1'b0; adv_req = 1'b1;
        step();
        rst_n = 1'b0; adv_req = 1'b0;
        #1;
        chk("t6_rdv", rdv_fft, 0);
        chk("t6_rdr", rdr_fft, 0);
        chk("t6_phase", phase, 0);
        chk("t6_ack", adv_ack, 0);
        chk("t6_drop", drop_err, 0);
        chk("t6_ract_ram", ract_ram, 0);
        step();
        step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            #2;
            if (rdv_fft || rdv_dma || adv_ack) cnt++;
            step();
        end
        chk("t6_no_stray", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
